// File: rtl/song_seq_ctrl.sv
// Playback sequencer for the note-ROM address path: start/pause/stop, per-beat note advance,
// loop or single-shot end of song. Optional tempo input enabled by SONG_SEQ_TEMPO_EN.
module song_seq_ctrl #(
    parameter int unsigned SONG_W    = 1,
    parameter int unsigned NOTE_W    = 4,
    parameter int unsigned LAST_NOTE = 15,
    parameter int unsigned BEAT_CYC  = 12500000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     stop,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic                     loop_en,
`ifdef SONG_SEQ_TEMPO_EN
    input  logic [1:0]               tempo,
`endif
    output logic [SONG_W+NOTE_W-1:0] addr_out,
    output logic                     note_strobe,
    output logic                     playing,
    output logic                     done
);

    localparam int unsigned CNT_W = $clog2(BEAT_CYC);

    typedef enum logic [1:0] {StIdle, StPlay, StPause} state_e;

    state_e            state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  beat_last;

`ifdef SONG_SEQ_TEMPO_EN
    logic [CNT_W-1:0] last_q, last_d, last_new;

    // Beat length shrinks by powers of two but never below two cycles.
    function automatic logic [CNT_W-1:0] beat_last_for(input logic [1:0] t);
        int unsigned len;
        len = BEAT_CYC >> t;
        if (len < 2) len = 2;
        return CNT_W'(len - 1);
    endfunction

    assign last_new  = beat_last_for(tempo);
    assign beat_last = last_q;

    always_ff @(posedge clk) begin
        if (reset) last_q <= CNT_W'(BEAT_CYC - 1);
        else       last_q <= last_d;
    end
`else
    assign beat_last = CNT_W'(BEAT_CYC - 1);
`endif

    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        note_d   = note_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
`ifdef SONG_SEQ_TEMPO_EN
        last_d   = last_q;
`endif
        if (stop) begin
            state_d = StIdle;
            note_d  = '0;
            cnt_d   = '0;
        end else if (start) begin
            state_d  = StPlay;
            song_d   = song_sel;
            note_d   = '0;
            cnt_d    = '0;
            strobe_d = 1'b1;
`ifdef SONG_SEQ_TEMPO_EN
            last_d   = last_new;
`endif
        end else begin
            case (state_q)
                StIdle: ;
                StPlay: begin
                    // A pause on the beat-end cycle defers the advance until after resume.
                    if (pause) begin
                        state_d = StPause;
                    end else if (cnt_q == beat_last) begin
                        cnt_d = '0;
`ifdef SONG_SEQ_TEMPO_EN
                        last_d = last_new;
`endif
                        if (note_q != NOTE_W'(LAST_NOTE)) begin
                            note_d   = note_q + NOTE_W'(1);
                            strobe_d = 1'b1;
                        end else if (loop_en) begin
                            note_d   = '0;
                            strobe_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                            note_d  = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StPause: begin
                    if (pause) state_d = StPlay;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            song_q   <= '0;
            note_q   <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            song_q   <= song_d;
            note_q   <= note_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign addr_out    = {song_q, note_q};
    assign note_strobe = strobe_q;
    assign playing     = (state_q != StIdle);
    assign done        = done_q;

endmodule

// File: tb/tb_song_seq_ctrl.sv
// Self-checking bench for song_seq_ctrl: vector table, directed corner cases, and randomized
// pulses against a remaining-time reference model.
module tb_song_seq_ctrl;

    localparam int unsigned SONG_W    = 1;
    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned LAST_NOTE = 15;
    localparam int unsigned BEAT_CYC  = 4;
    localparam int unsigned ADDR_W    = SONG_W + NOTE_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic [SONG_W-1:0] song_sel = '0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] addr_out;
    logic              note_strobe, playing, done;

    song_seq_ctrl #(
        .SONG_W(SONG_W), .NOTE_W(NOTE_W), .LAST_NOTE(LAST_NOTE), .BEAT_CYC(BEAT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .song_sel(song_sel), .loop_en(loop_en),
`ifdef SONG_SEQ_TEMPO_EN
        .tempo(2'd0),
`endif
        .addr_out(addr_out), .note_strobe(note_strobe), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: mode 0 idle, 1 playing, 2 paused; remain = play cycles left in the note.
    int m_mode = 0, m_song = 0, m_note = 0, m_remain = BEAT_CYC;
    logic m_strobe = 1'b0, m_done = 1'b0;

    function automatic void model_update();
        m_strobe = 1'b0;
        m_done   = 1'b0;
        if (reset) begin
            m_mode = 0; m_song = 0; m_note = 0; m_remain = BEAT_CYC;
        end else if (stop) begin
            m_mode = 0; m_note = 0; m_remain = BEAT_CYC;
        end else if (start) begin
            m_mode = 1; m_song = int'(song_sel); m_note = 0; m_remain = BEAT_CYC; m_strobe = 1'b1;
        end else if (m_mode == 1) begin
            if (pause) m_mode = 2;
            else if (m_remain > 1) m_remain--;
            else begin
                m_remain = BEAT_CYC;
                if (m_note < LAST_NOTE) begin
                    m_note++; m_strobe = 1'b1;
                end else if (loop_en) begin
                    m_note = 0; m_strobe = 1'b1;
                end else begin
                    m_mode = 0; m_note = 0; m_done = 1'b1;
                end
            end
        end else if (m_mode == 2 && pause) begin
            m_mode = 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check(input string name, input logic [ADDR_W-1:0] ea, input logic es,
                         input logic ep, input logic ed);
        n_total++;
        if (addr_out === ea && note_strobe === es && playing === ep && done === ed) n_pass++;
        else $display("FAIL %s: got addr=%h strobe=%b playing=%b done=%b, want addr=%h strobe=%b playing=%b done=%b",
                      name, addr_out, note_strobe, playing, done, ea, es, ep, ed);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    task automatic check_model(input string name);
        check(name, ADDR_W'((m_song << NOTE_W) | m_note), m_strobe, m_mode != 0, m_done);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic sel, input logic lp);
        song_sel = sel; loop_en = lp; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    typedef struct packed {
        logic [4:0] ins;   // {start, pause, stop, song_sel, loop_en}
        logic [4:0] addr;
        logic [2:0] outs;  // {note_strobe, playing, done}
    } vec_t;

    vec_t vecs[16];

    initial begin
        int strobes, cnt13, first14;
        vecs[0]  = {5'b10010, 5'h10, 3'b110};
        vecs[1]  = {5'b00000, 5'h10, 3'b010};
        vecs[2]  = {5'b00000, 5'h10, 3'b010};
        vecs[3]  = {5'b00000, 5'h10, 3'b010};
        vecs[4]  = {5'b00000, 5'h11, 3'b110};
        vecs[5]  = {5'b01000, 5'h11, 3'b010};
        vecs[6]  = {5'b00000, 5'h11, 3'b010};
        vecs[7]  = {5'b01000, 5'h11, 3'b010};
        vecs[8]  = {5'b00000, 5'h11, 3'b010};
        vecs[9]  = {5'b00000, 5'h11, 3'b010};
        vecs[10] = {5'b00000, 5'h11, 3'b010};
        vecs[11] = {5'b00000, 5'h12, 3'b110};
        vecs[12] = {5'b10100, 5'h10, 3'b000};
        vecs[13] = {5'b01000, 5'h10, 3'b000};
        vecs[14] = {5'b10000, 5'h00, 3'b110};
        vecs[15] = {5'b00100, 5'h00, 3'b000};

        do_reset();
        check("reset_state", 5'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            {start, pause, stop, song_sel, loop_en} = vecs[i].ins;
            step();
            check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].outs[2], vecs[i].outs[1],
                  vecs[i].outs[0]);
        end
        {start, pause, stop, song_sel, loop_en} = 5'b0;

        // Reset held three cycles mid-play.
        pulse_start(1'b1, 1'b1);
        for (int k = 0; k < 9; k++) step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset_mid_play", 5'h00, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b0;

        // Single-shot song: 16 notes of BEAT_CYC cycles, then one done pulse.
        strobes = 0;
        pulse_start(1'b1, 1'b0);
        for (int k = 0; k < 64; k++) begin
            if (k > 0) step();
            check("single_note", ADDR_W'(16 + k / 4), (k % 4) == 0, 1'b1, 1'b0);
            strobes += int'(note_strobe);
        end
        step();
        check("single_done", 5'h10, 1'b0, 1'b0, 1'b1);
        step();
        check("single_after", 5'h10, 1'b0, 1'b0, 1'b0);
        check_int("strobe_count", strobes, 16);

        // Looping song wraps to note 0 with a strobe and no done.
        pulse_start(1'b1, 1'b1);
        for (int k = 1; k < 64; k++) step();
        check("loop_last", 5'h1F, 1'b0, 1'b1, 1'b0);
        step();
        check("loop_wrap", 5'h10, 1'b1, 1'b1, 1'b0);
        stop = 1'b1; step(); stop = 1'b0;

        // Pause two cycles into note 3, resume seven cycles later.
        cnt13 = 0; first14 = -1;
        pulse_start(1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            pause = (k == 14 || k == 21);
            step();
            check_model("pause_model");
            if (addr_out == 5'h13) cnt13++;
            if (addr_out == 5'h14 && first14 < 0) first14 = k;
        end
        pause = 1'b0;
        check_int("pause_note3_len", cnt13, BEAT_CYC + 1 + 7);
        check_int("pause_note4_edge", first14, 24);

        // Stop and start together during note 5: stop wins.
        pulse_start(1'b1, 1'b0);
        for (int k = 1; k < 22; k++) step();
        check("note5", 5'h15, 1'b0, 1'b1, 1'b0);
        stop = 1'b1; start = 1'b1; song_sel = 1'b0;
        step();
        stop = 1'b0; start = 1'b0;
        check("stop_start", 5'h10, 1'b0, 1'b0, 1'b0);
        step();
        check("stop_hold", 5'h10, 1'b0, 1'b0, 1'b0);

        // Randomized pulses against the reference model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            reset    = ($urandom_range(0, 599) == 0);
            stop     = ($urandom_range(0, 79) == 0);
            start    = ($urandom_range(0, 49) == 0);
            pause    = ($urandom_range(0, 14) == 0);
            song_sel = SONG_W'($urandom);
            loop_en  = ($urandom_range(0, 3) != 0);
            step();
            check_model("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
